// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared MU0 sequencer state encoding, opcode map and counter width
package mu0_pkg;

    localparam int MU0_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STO = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JGE = 4'b0101;
    localparam logic [3:0] OP_JNE = 4'b0110;
    localparam logic [3:0] OP_STP = 4'b0111;

endpackage

// File: rtl/mu0_sequencer.sv
// rtl/mu0_sequencer.sv - MU0 phase sequencer with skip, wait states, halt and retire counter
// Optional single-step return-to-IDLE is enabled by defining SEQ_STEP_EN.
module mu0_sequencer
    import mu0_pkg::*;
#(
    parameter int CNT_W    = MU0_CNT_W,
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             MEM_READY,
    input  logic             EXTRA,
    input  logic [3:0]       IR_OP,
    input  logic             SKIP_SET,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             IR_LOAD,
    output logic             SKIPSTATUS,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    localparam state_t RESET_STATE = AUTO_RUN ? S_FETCH : S_IDLE;

    state_t state, state_nxt;
    logic   skip_pending, skip_pending_nxt;
    logic   skip_nxt;
    logic   retire;
    logic   step_mode;
    state_t retire_to;

`ifdef SEQ_STEP_EN
    assign step_mode = STEP;
`else
    logic step_unused;
    assign step_unused = STEP;
    assign step_mode   = 1'b0;
`endif

    assign retire_to = step_mode ? S_IDLE : S_FETCH;

    always_comb begin
        state_nxt        = state;
        retire           = 1'b0;
        skip_pending_nxt = skip_pending;
        skip_nxt         = SKIPSTATUS;
        case (state)
            S_IDLE: begin
                if (RUN) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (MEM_READY) begin
                    state_nxt        = S_EXEC1;
                    skip_nxt         = skip_pending;
                    skip_pending_nxt = 1'b0;
                end
            end
            S_EXEC1: begin
                // A skipped STP is just a no-op and must fall through to normal retirement.
                if (IR_OP == OP_STP && !SKIPSTATUS) begin
                    state_nxt = S_HALT;
                    retire    = 1'b1;
                end else if (EXTRA) begin
                    state_nxt = S_EXEC2;
                end else begin
                    state_nxt = retire_to;
                    retire    = 1'b1;
                end
            end
            S_EXEC2: begin
                if (MEM_READY) begin
                    state_nxt = retire_to;
                    retire    = 1'b1;
                end
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        // Skips never chain: a skipped instruction cannot arm another skip.
        if ((state == S_EXEC1 || state == S_EXEC2) && SKIP_SET && !SKIPSTATUS)
            skip_pending_nxt = 1'b1;
        if (retire)
            skip_nxt = 1'b0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= RESET_STATE;
            skip_pending <= 1'b0;
            SKIPSTATUS   <= 1'b0;
            INSTR_COUNT  <= '0;
        end else begin
            state        <= state_nxt;
            skip_pending <= skip_pending_nxt;
            SKIPSTATUS   <= skip_nxt;
            if (retire)
                INSTR_COUNT <= INSTR_COUNT + CNT_W'(1);
        end
    end

    assign FETCH   = (state == S_FETCH);
    assign EXEC1   = (state == S_EXEC1);
    assign EXEC2   = (state == S_EXEC2);
    assign HALTED  = (state == S_HALT);
    assign IR_LOAD = FETCH & MEM_READY;

endmodule

// File: tb/tb_mu0_sequencer.sv
// tb/tb_mu0_sequencer.sv - scoreboard bench for mu0_sequencer (CNT_W=4 to exercise wrap)
module tb_mu0_sequencer;
    import mu0_pkg::*;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC1 = 2;
    localparam int P_EXEC2 = 3;
    localparam int P_HALT  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, step, mem_ready, extra, skip_set;
    logic [3:0] ir_op;
    logic       fetch, exec1, exec2, ir_load, skipstatus, halted;
    logic [3:0] instr_count;

    typedef struct {
        int         id;
        logic [9:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mu0_sequencer #(.CNT_W(4), .AUTO_RUN(1'b0)) dut (
        .CLK(clk), .RESET_N(rst_n), .RUN(run), .STEP(step),
        .MEM_READY(mem_ready), .EXTRA(extra), .IR_OP(ir_op), .SKIP_SET(skip_set),
        .FETCH(fetch), .EXEC1(exec1), .EXEC2(exec2), .IR_LOAD(ir_load),
        .SKIPSTATUS(skipstatus), .HALTED(halted), .INSTR_COUNT(instr_count)
    );

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input logic r, input logic mr, input logic ex, input logic [3:0] op,
                       input logic ss, input logic st, input int ph, input logic irl,
                       input logic sk, input int cnt);
        exp_t e;
        run = r; mem_ready = mr; extra = ex; ir_op = op; skip_set = ss; step = st;
        e.id  = n_vec;
        e.vec = {ph == P_FETCH, ph == P_EXEC1, ph == P_EXEC2, irl, sk, ph == P_HALT, 4'(cnt)};
        n_vec++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e   = exp_q.pop_front();
            act = {fetch, exec1, exec2, ir_load, skipstatus, halted, instr_count};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL vec%0d {fetch,exec1,exec2,ir_load,skip,halted,count} got %b required %b",
                         e.id, act, e.vec);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        run = 0; step = 0; mem_ready = 0; extra = 0; ir_op = 4'd0; skip_set = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        cyc(0, 0, 0, OP_LDA, 0, 0, P_IDLE, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 1, 0, OP_LDA, 0, 0, P_IDLE, 0, 0, 0);
        // RUN, LDA with EXTRA: FETCH, EXEC1, EXEC2, FETCH
        cyc(1, 0, 0, OP_LDA, 0, 0, P_IDLE, 0, 0, 0);
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 0);
        cyc(0, 1, 1, OP_LDA, 0, 0, P_EXEC1, 0, 0, 0);
        cyc(0, 1, 0, OP_LDA, 0, 0, P_EXEC2, 0, 0, 0);
        // Three wait states in FETCH; instruction N sets skip in EXEC1
        cyc(0, 0, 0, OP_LDA, 0, 0, P_FETCH, 0, 0, 1);
        cyc(0, 0, 0, OP_LDA, 0, 0, P_FETCH, 0, 0, 1);
        cyc(0, 0, 0, OP_LDA, 0, 0, P_FETCH, 0, 0, 1);
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 1);
        cyc(0, 1, 0, OP_ADD, 1, 0, P_EXEC1, 0, 0, 1);
        // N+1 is a skipped STP: no halt, SKIP_SET ignored
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 2);
        cyc(0, 0, 0, OP_STP, 1, 0, P_EXEC1, 0, 1, 2);
        // N+2 unskipped, EXEC2 with one wait state, sets skip in EXEC2
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 3);
        cyc(0, 0, 1, OP_LDA, 0, 0, P_EXEC1, 0, 0, 3);
        cyc(0, 0, 0, OP_LDA, 0, 0, P_EXEC2, 0, 0, 3);
        cyc(0, 1, 0, OP_LDA, 1, 0, P_EXEC2, 0, 0, 3);
        // Skipped instruction with EXTRA keeps SKIPSTATUS through EXEC2
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 4);
        cyc(0, 0, 1, OP_LDA, 0, 0, P_EXEC1, 0, 1, 4);
        cyc(0, 1, 0, OP_LDA, 0, 0, P_EXEC2, 0, 1, 4);
        // Unskipped STP halts (beats EXTRA), counts once, ignores RUN
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 5);
        cyc(0, 0, 1, OP_STP, 0, 0, P_EXEC1, 0, 0, 5);
        cyc(1, 1, 0, OP_LDA, 0, 0, P_HALT, 0, 0, 6);
        cyc(1, 0, 0, OP_LDA, 0, 0, P_HALT, 0, 0, 6);
        cyc(0, 0, 0, OP_LDA, 0, 0, P_HALT, 0, 0, 6);
        rst_n = 1'b0;
        cyc(0, 0, 0, OP_LDA, 0, 0, P_IDLE, 0, 0, 0);
        rst_n = 1'b1;
        // 17 single-phase instructions wrap the 4-bit counter to 1
        cyc(1, 0, 0, OP_LDA, 0, 0, P_IDLE, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, i);
            cyc(0, 0, 0, OP_ADD, 0, 0, P_EXEC1, 0, 0, i);
        end
        cyc(0, 0, 0, OP_LDA, 0, 0, P_FETCH, 0, 0, 1);
        // Mid-instruction reset discards the partial instruction
        cyc(0, 1, 0, OP_LDA, 0, 0, P_FETCH, 1, 0, 1);
        cyc(0, 0, 1, OP_LDA, 0, 0, P_EXEC1, 0, 0, 1);
        rst_n = 1'b0;
        cyc(0, 1, 0, OP_LDA, 0, 0, P_IDLE, 0, 0, 0);
        rst_n = 1'b1;
        // Single step
        cyc(1, 0, 0, OP_LDA, 0, 1, P_IDLE, 0, 0, 0);
        cyc(0, 1, 0, OP_LDA, 0, 1, P_FETCH, 1, 0, 0);
        cyc(0, 0, 0, OP_ADD, 0, 1, P_EXEC1, 0, 0, 0);
`ifdef SEQ_STEP_EN
        cyc(0, 1, 0, OP_LDA, 0, 1, P_IDLE, 0, 0, 1);
        cyc(1, 0, 0, OP_LDA, 0, 1, P_IDLE, 0, 0, 1);
        cyc(0, 1, 0, OP_LDA, 0, 1, P_FETCH, 1, 0, 1);
        cyc(0, 0, 0, OP_ADD, 0, 1, P_EXEC1, 0, 0, 1);
        cyc(0, 0, 0, OP_LDA, 0, 1, P_IDLE, 0, 0, 2);
        cyc(1, 0, 0, OP_LDA, 0, 1, P_IDLE, 0, 0, 2);
        cyc(0, 1, 0, OP_LDA, 0, 1, P_FETCH, 1, 0, 2);
        cyc(0, 0, 0, OP_STP, 0, 1, P_EXEC1, 0, 0, 2);
        cyc(0, 0, 0, OP_LDA, 0, 1, P_HALT, 0, 0, 3);
`else
        cyc(0, 1, 0, OP_LDA, 0, 1, P_FETCH, 1, 0, 1);
        cyc(0, 0, 0, OP_ADD, 0, 1, P_EXEC1, 0, 0, 1);
        cyc(0, 0, 0, OP_LDA, 0, 1, P_FETCH, 0, 0, 2);
`endif
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
